unwrapper: RTL and testbench

UNWRAPPER -- requirements
Module: unwrapper

---
 rtl/unwrapper_pkg.sv | 29 ++
 rtl/unwrapper_if.sv | 29 ++
 rtl/unwrapper_byte_fifo.sv | 48 ++++
 rtl/unwrapper.sv | 105 ++++++++++
 tb/tb_unwrapper.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unwrapper_pkg.sv
// rtl/unwrapper_pkg.sv - shared types and constants for the byte-to-bit unwrapper
package unwrapper_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int NBITS_W    = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic               last;
        logic [NBITS_W-1:0] nbits;
        logic [BYTE_W-1:0]  data;
    } byte_entry_t;

    // Number of bits a byte contributes; a final byte with nbits==0 is a full byte.
    function automatic logic [CNT_W-1:0] load_count(input byte_entry_t e);
        if (e.last && (e.nbits != '0)) begin
            return {1'b0, e.nbits};
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/unwrapper_if.sv
// rtl/unwrapper_if.sv - byte-in / bit-out handshake bundle for the unwrapper
interface unwrapper_if;
    import unwrapper_pkg::*;

    logic [BYTE_W-1:0]  byte_in_i;
    logic               byte_in_vld_i;
    logic               byte_last_i;
    logic [NBITS_W-1:0] byte_nbits_i;
    logic               byte_in_rdy_o;
    logic               bit_out_o;
    logic               bit_out_vld_o;
    logic               bit_out_rdy_i;
    logic               bit_out_last_o;
    logic               decode_finish_i;
    logic               busy_o;

    modport slave (
        input  byte_in_i, byte_in_vld_i, byte_last_i, byte_nbits_i,
        input  bit_out_rdy_i, decode_finish_i,
        output byte_in_rdy_o, bit_out_o, bit_out_vld_o, bit_out_last_o, busy_o
    );

    modport master (
        output byte_in_i, byte_in_vld_i, byte_last_i, byte_nbits_i,
        output bit_out_rdy_i, decode_finish_i,
        input  byte_in_rdy_o, bit_out_o, bit_out_vld_o, bit_out_last_o, busy_o
    );

endinterface

// File: rtl/unwrapper_byte_fifo.sv
// rtl/unwrapper_byte_fifo.sv - two-entry registered FIFO of {last, nbits, byte}
module unwrapper_byte_fifo
    import unwrapper_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  byte_entry_t push_data_i,
    input  logic        pop_i,
    output byte_entry_t head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [1:0]  level_o
);

    byte_entry_t mem_q [FIFO_DEPTH];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  level_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 2'd1;
                2'b01:   level_q <= level_q - 2'd1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == 2'd2);
    assign empty_o = (level_q == 2'd0);
    assign level_o = level_q;

endmodule

// File: rtl/unwrapper.sv
// rtl/unwrapper.sv - serialises packed bytes LSB-first into a bit stream for the decoder
module unwrapper
    import unwrapper_pkg::*;
(
    input  logic      clk_i,
    input  logic      reset_i,
    unwrapper_if.slave bus
);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sh_last_q, sh_last_d;

    byte_entry_t fifo_head, in_entry, load_entry;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [1:0]  fifo_level, fifo_level_d;
    logic        finish, in_rdy, bit_vld, bit_last;
    logic        byte_xfer, bit_xfer, final_xfer, loadable, bypass;

    assign finish   = bus.decode_finish_i;
    assign in_rdy   = !fifo_full && (state_q != DONE);
    assign bit_vld  = (cnt_q != '0) && (state_q != DONE);
    assign bit_last = bit_vld && (cnt_q == 4'd1) && sh_last_q;

    assign byte_xfer  = bus.byte_in_vld_i && in_rdy && !finish;
    assign bit_xfer   = bit_vld && bus.bit_out_rdy_i && !finish;
    assign final_xfer = bit_xfer && bit_last;

    // Reload when empty or as the last buffered bit leaves, so bits stay back-to-back.
    assign loadable  = (state_q != DONE) && !final_xfer &&
                       ((cnt_q == '0) || ((cnt_q == 4'd1) && bit_xfer));
    assign fifo_pop  = loadable && !fifo_empty;
    assign bypass    = loadable && fifo_empty && byte_xfer;
    assign fifo_push = byte_xfer && !bypass;

    assign in_entry   = {bus.byte_last_i, bus.byte_nbits_i, bus.byte_in_i};
    assign load_entry = fifo_pop ? fifo_head : in_entry;

    unwrapper_byte_fifo u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (finish),
        .push_i      (fifo_push),
        .push_data_i (in_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i || finish) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            sh_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            sh_last_q <= sh_last_d;
        end
    end

    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sh_last_d    = sh_last_q;
        state_d      = state_q;
        fifo_level_d = fifo_level + {1'b0, fifo_push} - {1'b0, fifo_pop};

        if (fifo_pop || bypass) begin
            shreg_d   = load_entry.data;
            cnt_d     = load_count(load_entry);
            sh_last_d = load_entry.last;
        end else if (bit_xfer) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (byte_xfer) state_d = SHIFT;
            end
            SHIFT: begin
                if (final_xfer) begin
                    state_d = DONE;
                end else if ((cnt_d == '0) && (fifo_level_d == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.byte_in_rdy_o  = in_rdy;
    assign bus.bit_out_o      = shreg_q[0];
    assign bus.bit_out_vld_o  = bit_vld;
    assign bus.bit_out_last_o = bit_last;
    assign bus.busy_o         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_unwrapper.sv
// tb/tb_unwrapper.sv - randomized and directed self-checking bench for unwrapper
module tb_unwrapper;

    logic clk;
    logic reset;
    unwrapper_if u_if ();

    unwrapper dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;
    int n_bits_seen = 0;
    logic toggle_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the stream as an ordered list of {last, bit} still owed to the decoder.
    logic [1:0] exp_q[$];
    logic       m_done = 1'b0;

    always @(negedge clk) begin
        if (reset || u_if.decode_finish_i) begin
            exp_q.delete();
            m_done = 1'b0;
        end else begin
            check_eq("mon_vld", u_if.bit_out_vld_o, exp_q.size() != 0);
            check_eq("mon_busy", u_if.busy_o, (exp_q.size() != 0) || m_done);
            if (m_done) check_eq("mon_rdy_done", u_if.byte_in_rdy_o, 1'b0);
            else if (exp_q.size() == 0) check_eq("mon_rdy_empty", u_if.byte_in_rdy_o, 1'b1);
            if (u_if.bit_out_vld_o && u_if.bit_out_rdy_i && exp_q.size() != 0) begin
                logic [1:0] e;
                e = exp_q.pop_front();
                n_bits_seen++;
                check_eq("mon_bit", u_if.bit_out_o, e[0]);
                check_eq("mon_last", u_if.bit_out_last_o, e[1]);
                if (e[1]) begin
                    m_done = 1'b1;
                    exp_q.delete();
                end
            end
            if (u_if.byte_in_vld_i && u_if.byte_in_rdy_o) begin
                int nb;
                logic [7:0] d;
                d  = u_if.byte_in_i;
                nb = (u_if.byte_last_i && u_if.byte_nbits_i != 0) ? int'(u_if.byte_nbits_i) : 8;
                for (int i = 0; i < nb; i++) exp_q.push_back({u_if.byte_last_i && (i == nb - 1), d[i]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) u_if.bit_out_rdy_i = ~u_if.bit_out_rdy_i;
    endtask

    task automatic offer(input logic [7:0] d, input logic l, input logic [2:0] nb);
        u_if.byte_in_i     = d;
        u_if.byte_in_vld_i = 1'b1;
        u_if.byte_last_i   = l;
        u_if.byte_nbits_i  = nb;
    endtask

    task automatic pulse_finish();
        u_if.decode_finish_i = 1'b1;
        tick();
        u_if.decode_finish_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bit"}, u_if.bit_out_o, 1'b0);
        check_eq({tag, "_vld"}, u_if.bit_out_vld_o, 1'b0);
        check_eq({tag, "_last"}, u_if.bit_out_last_o, 1'b0);
        check_eq({tag, "_busy"}, u_if.busy_o, 1'b0);
        check_eq({tag, "_rdy"}, u_if.byte_in_rdy_o, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a5_bits;
        logic [15:0] two_bytes;
        int          n0, waited;
        bit          ok;

        reset = 1'b1;
        u_if.byte_in_i = '0; u_if.byte_in_vld_i = 1'b0; u_if.byte_last_i = 1'b0;
        u_if.byte_nbits_i = '0; u_if.bit_out_rdy_i = 1'b1; u_if.decode_finish_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // 0xA5, not last: eight bits LSB-first starting one cycle after acceptance
        a5_bits = 8'b1010_0101;
        offer(8'hA5, 1'b0, 3'd0);
        tick();
        u_if.byte_in_vld_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("a5_vld", u_if.bit_out_vld_o, 1'b1);
            check_eq("a5_bit", u_if.bit_out_o, a5_bits[i]);
            check_eq("a5_last", u_if.bit_out_last_o, 1'b0);
            tick();
        end
        check_eq("a5_end_vld", u_if.bit_out_vld_o, 1'b0);
        check_eq("a5_end_busy", u_if.busy_o, 1'b0);

        // 0x3C then 0xFF (last, full byte) back-to-back: 16 contiguous bits
        two_bytes = 16'hFF3C;
        offer(8'h3C, 1'b0, 3'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) offer(8'hFF, 1'b1, 3'd0);
            if (i == 1) begin u_if.byte_in_vld_i = 1'b0; u_if.byte_last_i = 1'b0; end
            check_eq("b2b_vld", u_if.bit_out_vld_o, 1'b1);
            check_eq("b2b_bit", u_if.bit_out_o, two_bytes[i]);
            check_eq("b2b_last", u_if.bit_out_last_o, i == 15);
            tick();
        end
        check_eq("b2b_done_vld", u_if.bit_out_vld_o, 1'b0);
        check_eq("b2b_done_rdy", u_if.byte_in_rdy_o, 1'b0);
        check_eq("b2b_done_busy", u_if.busy_o, 1'b1);
        pulse_finish();
        check_reset_outputs("b2b_finish");

        // 0x06 last with nbits=3: only 0,1,1
        offer(8'h06, 1'b1, 3'd3);
        tick();
        u_if.byte_in_vld_i = 1'b0; u_if.byte_last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("nb3_vld", u_if.bit_out_vld_o, 1'b1);
            check_eq("nb3_bit", u_if.bit_out_o, (i == 0) ? 1'b0 : 1'b1);
            check_eq("nb3_last", u_if.bit_out_last_o, i == 2);
            tick();
        end
        check_eq("nb3_done_vld", u_if.bit_out_vld_o, 1'b0);
        check_eq("nb3_done_rdy", u_if.byte_in_rdy_o, 1'b0);
        pulse_finish();

        // three queued bytes with a toggling decoder ready
        n0 = n_bits_seen;
        toggle_mode = 1'b1;
        u_if.bit_out_rdy_i = 1'b1;
        offer(8'h81, 1'b0, 3'd0); tick();
        offer(8'h7E, 1'b0, 3'd0); tick();
        offer(8'hC9, 1'b0, 3'd0); tick();
        u_if.byte_in_vld_i = 1'b0;
        check_eq("tog_full_rdy", u_if.byte_in_rdy_o, 1'b0);
        waited = 0;
        while (u_if.busy_o && waited < 200) begin tick(); waited++; end
        check_eq("tog_drain_timeout", waited < 200, 1'b1);
        check_eq("tog_bits", n_bits_seen - n0, 24);
        toggle_mode = 1'b0;
        u_if.bit_out_rdy_i = 1'b1;

        // decode_finish after four bits of a byte with another byte queued
        n0 = n_bits_seen;
        offer(8'h5A, 1'b0, 3'd0); tick();
        offer(8'hC3, 1'b0, 3'd0); tick();
        u_if.byte_in_vld_i = 1'b0;
        tick(); tick(); tick();
        check_eq("fin_pre_vld", u_if.bit_out_vld_o, 1'b1);
        pulse_finish();
        check_eq("fin_bits", n_bits_seen - n0, 4);
        check_reset_outputs("fin");

        // reset while shifting with the FIFO full
        u_if.bit_out_rdy_i = 1'b0;
        offer(8'h11, 1'b0, 3'd0); tick();
        offer(8'h22, 1'b0, 3'd0); tick();
        offer(8'h33, 1'b1, 3'd5); tick();
        u_if.byte_in_vld_i = 1'b0; u_if.byte_last_i = 1'b0;
        check_eq("rst_full_rdy", u_if.byte_in_rdy_o, 1'b0);
        check_eq("rst_full_vld", u_if.bit_out_vld_o, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst_mid");
        u_if.bit_out_rdy_i = 1'b1;
        tick(); tick();
        check_eq("rst_after_vld", u_if.bit_out_vld_o, 1'b0);

        // random streams against the model
        for (int s = 0; s < 40; s++) begin
            int  nbytes;
            bit  ends_last;
            nbytes    = $urandom_range(1, 5);
            ends_last = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < nbytes; b++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    u_if.bit_out_rdy_i = $urandom_range(0, 1);
                    tick();
                end
                offer(8'($urandom), ends_last && (b == nbytes - 1), 3'($urandom));
                ok = 1'b0;
                for (int w = 0; w < 60 && !ok; w++) begin
                    u_if.bit_out_rdy_i = $urandom_range(0, 1);
                    ok = u_if.byte_in_rdy_o;
                    tick();
                end
                check_eq("rnd_accept_timeout", ok, 1'b1);
                u_if.byte_in_vld_i = 1'b0;
                u_if.byte_last_i   = 1'b0;
            end
            waited = 0;
            while ((ends_last ? !m_done : u_if.busy_o) && waited < 400) begin
                u_if.bit_out_rdy_i = $urandom_range(0, 1);
                tick();
                waited++;
            end
            check_eq("rnd_drain_timeout", waited < 400, 1'b1);
            if (ends_last) begin
                tick();
                check_eq("rnd_done_vld", u_if.bit_out_vld_o, 1'b0);
                pulse_finish();
            end
            check_eq("rnd_idle_busy", u_if.busy_o, 1'b0);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
